// File: rtl/bus_pkg.sv
// Shared types and constants for the byte-bus responder.
// Build option: BUS_GPIO_EN enables the GPIO window at address[8]=1.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } resp_state_t;

  localparam logic [8:0] GPIO_OUT_ADDR = 9'h100;
  localparam logic [8:0] GPIO_IN_ADDR  = 9'h101;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

endpackage

// File: rtl/byte_ram.sv
// Byte RAM: one synchronous write port, one synchronous read port with a
// registered, resettable read output that holds until the next read.
module byte_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_responder.sv
// Responder for the grant_request/grant_given byte bus: RAM plus optional GPIO window.
// Build option: define BUS_GPIO_EN to decode address[8]=1 as the GPIO window.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant_request,
  input  logic              rw,
  input  logic [ADDR_W:0]   address,
  input  logic [DATA_W-1:0] data_in,
  output logic              grant_given,
  output logic [DATA_W-1:0] data_out,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out
);

  resp_state_t       r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [ADDR_W:0]   r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_idle;
  logic              w_load;
  logic              w_start;
  logic              w_to_grant;
  logic              w_acc_rw;
  logic [ADDR_W:0]   w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_gpio_sel;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_idle  = (r_state == IDLE);
  assign w_load  = w_idle && load_en;
  assign w_start = w_idle && !load_en && grant_request;

  // With no wait cycles the access happens on the capture edge, so use the live inputs then.
  assign w_acc_rw    = w_idle ? rw      : r_rw;
  assign w_acc_addr  = w_idle ? address : r_addr;
  assign w_acc_wdata = w_idle ? data_in : r_wdata;
  assign w_to_grant  = (w_start && (WAIT_CYCLES == 0)) || ((r_state == WAIT) && (r_cnt == 4'd0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= BUS_RD;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_rw    <= rw;
            r_addr  <= address;
            r_wdata <= data_in;
            if (WAIT_CYCLES == 0) begin
              r_state <= GRANT;
              r_cnt   <= 4'd0;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= GRANT;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        GRANT:   r_state <= RELEASE;
        RELEASE: if (!grant_request) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_given = (r_state == GRANT);

  assign w_ram_we    = w_load || (w_to_grant && (w_acc_rw == BUS_WR) && !w_gpio_sel);
  assign w_ram_re    = w_to_grant && (w_acc_rw == BUS_RD) && !w_gpio_sel;
  assign w_ram_waddr = w_load ? load_addr : w_acc_addr[ADDR_W-1:0];
  assign w_ram_wdata = w_load ? load_data : w_acc_wdata;

  byte_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_acc_addr[ADDR_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

`ifdef BUS_GPIO_EN
  logic              r_gpio_out;
  logic [DATA_W-1:0] r_gpio_q;
  logic              r_rd_gpio;
  logic [DATA_W-1:0] r_gpio_rd;
  logic              w_off_out;
  logic              w_off_in;

  assign w_gpio_sel = w_acc_addr[ADDR_W];
  assign w_off_out  = (w_acc_addr[ADDR_W-1:0] == ADDR_W'(GPIO_OUT_ADDR[7:0]));
  assign w_off_in   = (w_acc_addr[ADDR_W-1:0] == ADDR_W'(GPIO_IN_ADDR[7:0]));

  // data_out is sourced from whichever side served the most recent read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gpio_q  <= '0;
      r_rd_gpio <= 1'b0;
      r_gpio_rd <= '0;
    end else if (w_to_grant && w_gpio_sel) begin
      if (w_acc_rw == BUS_WR) begin
        if (w_off_out) r_gpio_q <= w_acc_wdata;
      end else begin
        r_rd_gpio <= 1'b1;
        r_gpio_rd <= w_off_out ? r_gpio_q : (w_off_in ? gpio_in : '0);
      end
    end else if (w_ram_re) begin
      r_rd_gpio <= 1'b0;
    end
  end

  assign r_gpio_out = 1'b0;
  assign gpio_out   = r_gpio_q;
  assign data_out   = r_rd_gpio ? r_gpio_rd : w_ram_rdata;
`else
  logic w_unused;

  assign w_gpio_sel = 1'b0;
  assign w_unused   = ^{gpio_in, w_acc_addr[ADDR_W]};
  assign gpio_out   = '0;
  assign data_out   = w_ram_rdata;
`endif

  a_load_only_idle: assert property (@(posedge clk) disable iff (!reset)
    load_en |-> (r_state == IDLE));

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized self-checking bench for bus_mem_responder against a transaction-level model.
// Three instances share all inputs: WAIT_CYCLES = 0, 1 and 15.
module tb_bus_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       grant_request = 1'b0;
  logic       rw = 1'b0;
  logic [8:0] address = '0;
  logic [7:0] data_in = '0;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [7:0] gpio_in = '0;

  logic [2:0] gnt;
  logic [7:0] dout [3];
  logic [7:0] gpo  [3];

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m_ram [256];
  logic [7:0] m_gpo = '0;

  always #5 clk = ~clk;

  bus_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .grant_request(grant_request), .rw(rw), .address(address),
    .data_in(data_in), .grant_given(gnt[0]), .data_out(dout[0]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .gpio_in(gpio_in), .gpio_out(gpo[0]));

  bus_mem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .grant_request(grant_request), .rw(rw), .address(address),
    .data_in(data_in), .grant_given(gnt[1]), .data_out(dout[1]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .gpio_in(gpio_in), .gpio_out(gpo[1]));

  bus_mem_responder #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset), .grant_request(grant_request), .rw(rw), .address(address),
    .data_in(data_in), .grant_given(gnt[2]), .data_out(dout[2]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .gpio_in(gpio_in), .gpio_out(gpo[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 0 : ((sel == 1) ? 1 : 15);
  endfunction

  function automatic logic [7:0] m_read(input logic [8:0] a);
`ifdef BUS_GPIO_EN
    if (a[8]) begin
      if (a == 9'h100) return m_gpo;
      if (a == 9'h101) return gpio_in;
      return 8'h00;
    end
`endif
    return m_ram[a[7:0]];
  endfunction

  task automatic m_write(input logic [8:0] a, input logic [7:0] d);
`ifdef BUS_GPIO_EN
    if (a[8]) begin
      if (a == 9'h100) m_gpo = d;
      return;
    end
`endif
    m_ram[a[7:0]] = d;
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk);
    m_ram[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One core-style access observed on instance sel; core inputs are scrambled after capture.
  task automatic access(input int sel, input logic wr, input logic [8:0] a, input logic [7:0] d,
                        input int hold, input bit with_load, input logic [7:0] la,
                        input logic [7:0] ld);
    int lat;
    bit seen;
    int cap;
    logic [7:0] exp_rd;
    cap = with_load ? 2 : 1;
    @(negedge clk);
    grant_request = 1'b1; rw = wr; address = a; data_in = d;
    if (with_load) begin
      load_en = 1'b1; load_addr = la; load_data = ld;
    end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (with_load && lat == 1) begin
        load_en = 1'b0;
        m_ram[la] = ld;
      end
      if (gnt[sel]) seen = 1'b1;
      else if (lat >= cap) begin
        address = 9'($urandom); rw = 1'($urandom); data_in = 8'($urandom);
      end
    end
    check($sformatf("latency%0d", sel), lat, wait_of(sel) + 1 + int'(with_load));
    exp_rd = m_read(a);
    if (wr) m_write(a, d);
    else check($sformatf("rd%0d@%0h", sel, a), dout[sel], exp_rd);
    for (int i = 0; i <= hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("single_grant%0d", sel), gnt[sel], 1'b0);
    end
    grant_request = 1'b0;
    if (!wr) check($sformatf("rd_hold%0d", sel), dout[sel], exp_rd);
    check($sformatf("gpio_out%0d", sel), gpo[sel], m_gpo);
    repeat (20) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] ra;
    #1 reset = 1'b0;
    #1;
    check("rst_grant", gnt[1], 1'b0);
    check("rst_dout", dout[1], 8'h00);
    check("rst_gpio", gpo[1], 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 256; i++) load_byte(8'(i), 8'($urandom));
    load_byte(8'h00, 8'h12);
    load_byte(8'h01, 8'h34);
    load_byte(8'h02, 8'h56);
    load_byte(8'h03, 8'h78);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) access(1, 1'b0, 9'(i), 8'h00, 0, 1'b0, 8'h00, 8'h00);

    access(1, 1'b1, 9'h080, 8'hA5, 2, 1'b0, 8'h00, 8'h00);
    access(1, 1'b0, 9'h080, 8'h00, 2, 1'b0, 8'h00, 8'h00);

    access(1, 1'b1, 9'h100, 8'h3C, 0, 1'b0, 8'h00, 8'h00);
    gpio_in = 8'hC3;
    access(1, 1'b0, 9'h101, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    access(1, 1'b1, 9'h101, 8'h55, 0, 1'b0, 8'h00, 8'h00);
    access(1, 1'b0, 9'h100, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    access(1, 1'b0, 9'h000, 8'h00, 0, 1'b0, 8'h00, 8'h00);

    access(1, 1'b0, 9'h002, 8'h00, 0, 1'b1, 8'h02, 8'h9A);

    for (int i = 0; i < 4; i++) begin
      access(0, 1'($urandom), 9'($urandom_range(0, 255)), 8'($urandom), 1, 1'b0, 8'h00, 8'h00);
      access(2, 1'($urandom), 9'($urandom_range(0, 255)), 8'($urandom), 1, 1'b0, 8'h00, 8'h00);
    end
    access(0, 1'b0, 9'h003, 8'h00, 0, 1'b1, 8'h03, 8'hE7);

    access(1, 1'b0, 9'h003, 8'h00, 0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    grant_request = 1'b1; rw = 1'b1; address = 9'h010; data_in = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check("wait_no_grant", gnt[1], 1'b0);
    reset = 1'b0;
    grant_request = 1'b0;
    #1;
    check("abort_grant", gnt[1], 1'b0);
    check("abort_dout", dout[1], 8'h00);
    m_gpo = 8'h00;
    check("abort_gpio", gpo[1], 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (20) @(posedge clk);
    access(1, 1'b0, 9'h010, 8'h00, 0, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 40; i++) begin
      gpio_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 9'h100 + 9'($urandom_range(0, 3));
      else ra = 9'($urandom_range(0, 511));
      access(1, 1'($urandom), ra, 8'($urandom), $urandom_range(0, 2), 1'b0, 8'h00, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
